rename_map_table: RTL and testbench

- Consumer end of the free-list interface. At dispatch it takes the free physical register (T_new) and returns the displaced mapping (T_old), which travels with the ROB entry and is later handed back to the free list at retire.
- Holds the speculative arch-to-phys map with per-entry ready bits, plus a committed (architectural) map updated at retire.
- On branch_incorrect, the speculative map is restored from the committed map, the same event that restores the free-list checkpoint.

---
 rtl/sys_defs.sv | 15 +
 rtl/map_lookup_port.sv | 23 ++
 rtl/rename_map_table.sv | 113 +++++++++++
 tb/tb_rename_map_table.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared register-file definitions for the rename stage: register counts,
// tag/index types and the no-destination tag used by the free list.
package sys_defs;

  localparam int NUM_ARCH_REG = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int PR_W         = $clog2(NUM_PHYS_REG);
  localparam int AR_W         = $clog2(NUM_ARCH_REG);

  typedef logic [PR_W-1:0] PHYS_REG;
  typedef logic [AR_W-1:0] ARCH_REG;

  localparam PHYS_REG ZERO_TAG = '1;

endpackage

// File: rtl/map_lookup_port.sv
// One source-operand read port of the rename map: tag lookup plus ready bit
// with a same-cycle bypass from the completion broadcast. r0 is always tag 0, ready.
module map_lookup_port
  import sys_defs::*;
(
  input  ARCH_REG                 src_arch,
  input  PHYS_REG                 map_q [NUM_ARCH_REG],
  input  logic [NUM_ARCH_REG-1:0] ready_q,
  input  logic                    cdb_valid,
  input  PHYS_REG                 cdb_tag,
  output PHYS_REG                 src_tag,
  output logic                    src_ready
);

  PHYS_REG mapped;
  logic    is_r0;

  assign mapped    = map_q[src_arch];
  assign is_r0     = (src_arch == '0);
  assign src_tag   = is_r0 ? '0 : mapped;
  assign src_ready = is_r0 | ready_q[src_arch] | (cdb_valid & (cdb_tag == mapped));

endmodule

// File: rtl/rename_map_table.sv
// Speculative and committed arch-to-phys rename maps with per-entry ready bits.
// Optional MT_DEBUG_EN exposes the raw map state on extra output ports.
module rename_map_table
  import sys_defs::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    dispatch_en,
  input  logic    id_no_dest_reg,
  input  ARCH_REG dest_arch,
  input  PHYS_REG free_reg,
  input  ARCH_REG src1_arch,
  input  ARCH_REG src2_arch,
  output PHYS_REG src1_tag,
  output PHYS_REG src2_tag,
  output logic    src1_ready,
  output logic    src2_ready,
  output PHYS_REG T_old,
  output PHYS_REG T_new,
  input  logic    cdb_valid,
  input  PHYS_REG cdb_tag,
  input  logic    retire_en,
  input  ARCH_REG retire_arch,
  input  PHYS_REG retire_T_new,
`ifdef MT_DEBUG_EN
  output PHYS_REG                 map_out      [NUM_ARCH_REG],
  output PHYS_REG                 arch_map_out [NUM_ARCH_REG],
  output logic [NUM_ARCH_REG-1:0] ready_out,
`endif
  input  logic    branch_incorrect
);

  PHYS_REG                 map_q  [NUM_ARCH_REG];
  PHYS_REG                 map_d  [NUM_ARCH_REG];
  PHYS_REG                 arch_q [NUM_ARCH_REG];
  PHYS_REG                 arch_d [NUM_ARCH_REG];
  logic [NUM_ARCH_REG-1:0] ready_q;
  logic [NUM_ARCH_REG-1:0] ready_d;
  logic                    rename;

  assign rename = dispatch_en & ~id_no_dest_reg & (dest_arch != '0);
  assign T_old  = rename ? map_q[dest_arch] : ZERO_TAG;
  assign T_new  = rename ? free_reg         : ZERO_TAG;

  map_lookup_port u_src1 (
    .src_arch  (src1_arch),
    .map_q     (map_q),
    .ready_q   (ready_q),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .src_tag   (src1_tag),
    .src_ready (src1_ready)
  );

  map_lookup_port u_src2 (
    .src_arch  (src2_arch),
    .map_q     (map_q),
    .ready_q   (ready_q),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .src_tag   (src2_tag),
    .src_ready (src2_ready)
  );

  // Recovery copies the committed map *after* this cycle's retire, so the
  // retire update is folded into arch_d before the mispredict mux.
  // NOTE: combinational next-state uses blocking '=' with every output defaulted
  // first, so later statements can override earlier ones and no latch is inferred.
  always_comb begin
    arch_d = arch_q;
    if (retire_en && (retire_arch != '0)) arch_d[retire_arch] = retire_T_new;

    map_d   = map_q;
    ready_d = ready_q;
    if (branch_incorrect) begin
      map_d   = arch_d;
      ready_d = '1;
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < NUM_ARCH_REG; i++) begin
          if (map_q[i] == cdb_tag) ready_d[i] = 1'b1;
        end
      end
      if (rename) begin
        map_d[dest_arch]   = free_reg;
        ready_d[dest_arch] = 1'b0;
      end
    end
  end

  // NOTE: these maps are architectural state, not a RAM, so every entry is reset
  // to the identity mapping; state registers use non-blocking '<=' only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) begin
        map_q[i]  <= PHYS_REG'(i);
        arch_q[i] <= PHYS_REG'(i);
      end
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      arch_q  <= arch_d;
      ready_q <= ready_d;
    end
  end

`ifdef MT_DEBUG_EN
  assign map_out      = map_q;
  assign arch_map_out = arch_q;
  assign ready_out    = ready_q;
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to an array model.
module tb_rename_map_table;
  import sys_defs::*;

  logic    clock = 1'b0;
  logic    reset;
  logic    dispatch_en, id_no_dest_reg;
  ARCH_REG dest_arch, src1_arch, src2_arch, retire_arch;
  PHYS_REG free_reg, cdb_tag, retire_T_new;
  PHYS_REG src1_tag, src2_tag, T_old, T_new;
  logic    src1_ready, src2_ready;
  logic    cdb_valid, retire_en, branch_incorrect;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer arrays, state as of the last clock edge.
  int m_map [32];
  int a_map [32];
  bit m_rdy [32];

  rename_map_table dut (
    .clock            (clock),
    .reset            (reset),
    .dispatch_en      (dispatch_en),
    .id_no_dest_reg   (id_no_dest_reg),
    .dest_arch        (dest_arch),
    .free_reg         (free_reg),
    .src1_arch        (src1_arch),
    .src2_arch        (src2_arch),
    .src1_tag         (src1_tag),
    .src2_tag         (src2_tag),
    .src1_ready       (src1_ready),
    .src2_ready       (src2_ready),
    .T_old            (T_old),
    .T_new            (T_new),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .retire_en        (retire_en),
    .retire_arch      (retire_arch),
    .retire_T_new     (retire_T_new),
    .branch_incorrect (branch_incorrect)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_tag(input int s);
    return (s == 0) ? 0 : m_map[s];
  endfunction

  function automatic int exp_rdy(input int s);
    if (s == 0) return 1;
    return (m_rdy[s] || (cdb_valid && int'(cdb_tag) == m_map[s])) ? 1 : 0;
  endfunction

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_map[i] = i; a_map[i] = i; m_rdy[i] = 1'b1;
      end
    end else begin
      bit ren;
      ren = dispatch_en && !id_no_dest_reg && (dest_arch != 0);
      check("m_src1_tag", src1_tag,   exp_tag(src1_arch));
      check("m_src2_tag", src2_tag,   exp_tag(src2_arch));
      check("m_src1_rdy", src1_ready, exp_rdy(src1_arch));
      check("m_src2_rdy", src2_ready, exp_rdy(src2_arch));
      check("m_t_old",    T_old, ren ? m_map[dest_arch] : 63);
      check("m_t_new",    T_new, ren ? int'(free_reg)   : 63);
      if (retire_en && retire_arch != 0) a_map[retire_arch] = retire_T_new;
      if (branch_incorrect) begin
        for (int i = 0; i < 32; i++) begin
          m_map[i] = a_map[i]; m_rdy[i] = 1'b1;
        end
      end else begin
        if (cdb_valid)
          for (int i = 0; i < 32; i++) if (m_map[i] == int'(cdb_tag)) m_rdy[i] = 1'b1;
        if (ren) begin
          m_map[dest_arch] = free_reg;
          m_rdy[dest_arch] = 1'b0;
        end
      end
    end
  end

  task automatic idle();
    dispatch_en = 0; id_no_dest_reg = 0; dest_arch = 0; free_reg = 0;
    src1_arch = 0; src2_arch = 0; cdb_valid = 0; cdb_tag = 0;
    retire_en = 0; retire_arch = 0; retire_T_new = 0; branch_incorrect = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic dispatch(input int d, input int f);
    dispatch_en = 1; dest_arch = ARCH_REG'(d); free_reg = PHYS_REG'(f);
  endtask

  initial begin
    idle();
    reset = 1;
    #12 reset = 0;
    next_cycle();

    // 1: reset state
    src1_arch = 5; src2_arch = 0;
    @(negedge clock);
    check("rst_src1_tag", src1_tag, 5);
    check("rst_src2_tag", src2_tag, 0);
    check("rst_src1_rdy", src1_ready, 1);
    check("rst_src2_rdy", src2_ready, 1);
    check("rst_t_old", T_old, 63);
    check("rst_t_new", T_new, 63);

    // 2: rename r3 -> 32, then CDB bypass and hold
    next_cycle(); dispatch(3, 32);
    @(negedge clock);
    check("d3_t_old", T_old, 3);
    check("d3_t_new", T_new, 32);
    next_cycle(); src1_arch = 3;
    @(negedge clock);
    check("r3_tag", src1_tag, 32);
    check("r3_not_rdy", src1_ready, 0);
    next_cycle(); src1_arch = 3; cdb_valid = 1; cdb_tag = 32;
    @(negedge clock);
    check("r3_bypass_rdy", src1_ready, 1);
    next_cycle(); src1_arch = 3;
    @(negedge clock);
    check("r3_held_rdy", src1_ready, 1);

    // 3: src == dest sees old mapping; dest r0 does nothing
    next_cycle(); dispatch(4, 33); src1_arch = 4;
    @(negedge clock);
    check("r4_old_tag", src1_tag, 4);
    check("r4_t_old", T_old, 4);
    next_cycle(); dispatch(0, 40); src1_arch = 4;
    @(negedge clock);
    check("r0_dest_t_old", T_old, 63);
    check("r0_dest_t_new", T_new, 63);
    check("r4_new_tag", src1_tag, 33);

    // 4: rename overrides a same-cycle CDB of the new tag
    next_cycle(); dispatch(7, 34); cdb_valid = 1; cdb_tag = 34;
    next_cycle(); src1_arch = 7;
    @(negedge clock);
    check("r7_tag", src1_tag, 34);
    check("r7_not_rdy", src1_ready, 0);

    // 5: rename r3 again, retire r3 -> 32, recover
    next_cycle(); dispatch(3, 35);
    @(negedge clock);
    check("r3b_t_old", T_old, 32);
    next_cycle(); retire_en = 1; retire_arch = 3; retire_T_new = 32;
    next_cycle(); branch_incorrect = 1;
    next_cycle(); src1_arch = 3; src2_arch = 7;
    @(negedge clock);
    check("rec_r3_tag", src1_tag, 32);
    check("rec_r3_rdy", src1_ready, 1);
    check("rec_r7_tag", src2_tag, 7);
    check("rec_r7_rdy", src2_ready, 1);
    next_cycle(); src1_arch = 4;
    @(negedge clock);
    check("rec_r4_tag", src1_tag, 4);

    // 6: recovery with simultaneous retire and dropped dispatch
    next_cycle(); branch_incorrect = 1; retire_en = 1; retire_arch = 9;
    retire_T_new = 40; dispatch(9, 41);
    next_cycle(); src1_arch = 9;
    @(negedge clock);
    check("br_r9_tag", src1_tag, 40);
    check("br_r9_rdy", src1_ready, 1);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      dispatch_en    = ($urandom_range(0, 3) != 0);
      id_no_dest_reg = ($urandom_range(0, 7) == 0);
      dest_arch      = ARCH_REG'($urandom_range(0, 31));
      free_reg       = PHYS_REG'($urandom_range(0, 62));
      src1_arch      = ARCH_REG'($urandom_range(0, 31));
      src2_arch      = ARCH_REG'($urandom_range(0, 31));
      cdb_valid      = ($urandom_range(0, 1) == 1);
      cdb_tag        = ($urandom_range(0, 3) != 0) ? PHYS_REG'(m_map[$urandom_range(0, 31)])
                                                   : PHYS_REG'($urandom_range(0, 63));
      retire_en      = ($urandom_range(0, 2) == 0);
      retire_arch    = ARCH_REG'($urandom_range(0, 31));
      retire_T_new   = PHYS_REG'($urandom_range(0, 62));
      branch_incorrect = ($urandom_range(0, 29) == 0);
    end

    // Make sure a few entries differ from identity, then reset mid-cycle
    next_cycle(); dispatch(10, 50);
    next_cycle(); dispatch(20, 51);
    next_cycle(); src1_arch = 10; src2_arch = 20;
    #2 reset = 1;
    #1;
    check("async_r10_tag", src1_tag, 10);
    check("async_r20_tag", src2_tag, 20);
    check("async_r10_rdy", src1_ready, 1);
    @(negedge clock);
    #2 reset = 0;
    next_cycle(); src1_arch = 10; src2_arch = 20;
    @(negedge clock);
    check("post_rst_r10", src1_tag, 10);
    check("post_rst_r20", src2_tag, 20);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
